mc_controller: RTL and testbench

Multi-cycle control unit for the RV32I-subset datapath. It replaces per-instruction combinational decode with a Moore FSM plus a small number of Mealy outputs. It sequences the shared ALU, a single unified memory port with a ready handshake, and the IR, PC, ALUOut and MDR registers. It adds parametrised extended branches, a memory-wait watchdog, a sticky illegal-instruction trap and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_controller_alu_decoder.sv | 25 ++
 rtl/mc_controller.sv | 214 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle control unit.
// States, opcodes, ALU codes and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_PC,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SA_PC  = 2'b00;
  localparam logic [1:0] SA_OLD = 2'b01;
  localparam logic [1:0] SA_RS1 = 2'b10;

  localparam logic [1:0] SB_RS2 = 2'b00;
  localparam logic [1:0] SB_IMM = 2'b01;
  localparam logic [1:0] SB_4   = 2'b10;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MDR    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;
  localparam logic [1:0] RS_IMM    = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic       adr_src;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [2:0] imm;
    logic [1:0] res;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: funct3/funct7 to ALU operation for R and I types.
// Subtract is only reachable from the register-register form.
module alu_decoder
  import mc_pkg::*;
(
  input  logic       i_is_r,
  input  logic [2:0] i_f3,
  input  logic [6:0] i_f7,
  output logic [2:0] o_alu_ctrl
);

  // map funct3 to an ALU code; funct7 only selects sub on R-type
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_f3)
      3'b000:  o_alu_ctrl = (i_is_r && i_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b111:  o_alu_ctrl = ALU_AND;
      3'b110:  o_alu_ctrl = ALU_OR;
      3'b100:  o_alu_ctrl = ALU_XOR;
      3'b010:  o_alu_ctrl = ALU_SLT;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM with unified memory port,
// watchdog on memory waits, sticky trap and retired-instruction count.
module mc_controller
  import mc_pkg::*;
#(
  parameter int BRANCH_EXT = 1,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       f3,
  input  logic [6:0]       f7,
  input  logic             zero,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             adr_src,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             reg_wr,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [31:0] WD_LIM =
    (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_wd;
  logic [CNT_W-1:0] r_instret;
  ctrl_t            w_c;
  ctrl_t            w_o;
  logic [2:0]       w_dec_alu;
  logic             w_is_ld;
  logic             w_br_ok;
  logic             w_taken;
  logic             w_wait;
  logic             w_wd_hit;

  alu_decoder u_dec (
    .i_is_r     (r_state == S_EXEC_R),
    .i_f3       (f3),
    .i_f7       (f7),
    .o_alu_ctrl (w_dec_alu)
  );

  assign w_is_ld = (op == OP_LW);
  assign w_br_ok = (f3 == 3'b000) || (f3 == 3'b001) ||
    ((BRANCH_EXT != 0) && (f3 == 3'b100 || f3 == 3'b101));
  assign w_wait  = w_c.mem_req && !mem_ready;
  assign w_wd_hit = (TIMEOUT > 0) && w_wait && (r_wd >= WD_LIM);

  // branch condition from the ALU flags of rs1-rs2
  always_comb begin
    w_taken = 1'b0;
    case (f3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = sign;
      3'b101:  w_taken = !sign;
      default: w_taken = 1'b0;
    endcase
  end

  // next-state selection; watchdog expiry overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_BR:        w_next = w_br_ok ? S_BRANCH : S_TRAP;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: w_next = w_is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_LUI: w_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_PC: w_next = S_ALU_WB;
      S_JALR:    w_next = S_JALR_PC;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_TRAP;
    endcase
    if (w_wd_hit) w_next = S_TRAP;
  end

  // datapath controls decoded from state; fetch and branch pc_wr are Mealy
  always_comb begin
    w_c = '0;
    case (r_state)
      S_FETCH: begin
        w_c.mem_req = 1'b1;
        w_c.src_a   = SA_PC;
        w_c.src_b   = SB_4;
        w_c.res     = RS_ALU;
        w_c.ir_wr   = mem_ready;
        w_c.pc_wr   = mem_ready;
      end
      S_DECODE: begin
        w_c.src_a = SA_OLD;
        w_c.src_b = SB_IMM;
        w_c.imm   = (op == OP_SW)  ? IMM_S :
                    (op == OP_BR)  ? IMM_B :
                    (op == OP_JAL) ? IMM_J :
                    (op == OP_LUI) ? IMM_U : IMM_I;
      end
      S_MEM_ADR: begin
        w_c.src_a = SA_RS1;
        w_c.src_b = SB_IMM;
        w_c.imm   = w_is_ld ? IMM_I : IMM_S;
      end
      S_MEM_RD: begin
        w_c.mem_req = 1'b1;
        w_c.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        w_c.res    = RS_MDR;
        w_c.reg_wr = 1'b1;
      end
      S_MEM_WR: begin
        w_c.mem_req = 1'b1;
        w_c.mem_wr  = 1'b1;
        w_c.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        w_c.src_a = SA_RS1;
        w_c.src_b = SB_RS2;
        w_c.alu   = w_dec_alu;
      end
      S_EXEC_I: begin
        w_c.src_a = SA_RS1;
        w_c.src_b = SB_IMM;
        w_c.imm   = IMM_I;
        w_c.alu   = w_dec_alu;
      end
      S_ALU_WB: begin
        w_c.res    = RS_ALUOUT;
        w_c.reg_wr = 1'b1;
      end
      S_BRANCH: begin
        w_c.src_a = SA_RS1;
        w_c.src_b = SB_RS2;
        w_c.alu   = ALU_SUB;
        w_c.imm   = IMM_B;
        w_c.res   = RS_ALUOUT;
        w_c.pc_wr = w_taken;
      end
      S_JAL, S_JALR_PC: begin
        w_c.src_a = SA_OLD;
        w_c.src_b = SB_4;
        w_c.res   = RS_ALUOUT;
        w_c.pc_wr = 1'b1;
      end
      S_JALR: begin
        w_c.src_a = SA_RS1;
        w_c.src_b = SB_IMM;
        w_c.imm   = IMM_I;
      end
      S_LUI: begin
        w_c.res    = RS_IMM;
        w_c.imm    = IMM_U;
        w_c.reg_wr = 1'b1;
      end
      S_TRAP:  w_c.illegal = 1'b1;
      default: w_c = '0;
    endcase
  end

  // state, watchdog and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wd      <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_wd    <= (w_wait && w_next == r_state) ? r_wd + 32'd1 : 32'd0;
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign w_o        = rst ? '0 : w_c;
  assign mem_req    = w_o.mem_req;
  assign mem_wr     = w_o.mem_wr;
  assign adr_src    = w_o.adr_src;
  assign ir_wr      = w_o.ir_wr;
  assign pc_wr      = w_o.pc_wr;
  assign reg_wr     = w_o.reg_wr;
  assign alu_src_a  = w_o.src_a;
  assign alu_src_b  = w_o.src_b;
  assign alu_ctrl   = w_o.alu;
  assign imm_src    = w_o.imm;
  assign result_src = w_o.res;
  assign illegal    = w_o.illegal;
  assign instret    = rst ? '0 : r_instret;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed bench for mc_controller with a cycle scoreboard.
// Two instances: restricted (no ext branches, watchdog 5, 4-bit count) and default.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic [2:0]  f3 = 3'd0;
  logic [6:0]  f7 = 7'd0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic        mem_ready = 1'b1;

  logic d_mem_req, d_mem_wr, d_adr_src, d_ir_wr, d_pc_wr, d_reg_wr, d_illegal;
  logic [1:0] d_a, d_b, d_res;
  logic [2:0] d_alu, d_imm;
  logic [3:0] d_instret;

  logic e_mem_req, e_mem_wr, e_adr_src, e_ir_wr, e_pc_wr, e_reg_wr, e_illegal;
  logic [1:0] e_a, e_b, e_res;
  logic [2:0] e_alu, e_imm;
  logic [31:0] e_instret;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_controller #(.BRANCH_EXT(0), .TIMEOUT(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .mem_req(d_mem_req), .mem_wr(d_mem_wr), .adr_src(d_adr_src),
    .ir_wr(d_ir_wr), .pc_wr(d_pc_wr), .reg_wr(d_reg_wr),
    .alu_src_a(d_a), .alu_src_b(d_b), .alu_ctrl(d_alu),
    .imm_src(d_imm), .result_src(d_res), .illegal(d_illegal),
    .instret(d_instret)
  );

  mc_controller dut2 (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .mem_req(e_mem_req), .mem_wr(e_mem_wr), .adr_src(e_adr_src),
    .ir_wr(e_ir_wr), .pc_wr(e_pc_wr), .reg_wr(e_reg_wr),
    .alu_src_a(e_a), .alu_src_b(e_b), .alu_ctrl(e_alu),
    .imm_src(e_imm), .result_src(e_res), .illegal(e_illegal),
    .instret(e_instret)
  );

  // [18]req [17]wr [16]adr [15]ir [14]pc [13]reg [12:11]a [10:9]b
  // [8:6]alu [5:3]imm [2:1]res [0]illegal
  logic [18:0] obs1, obs2, s2;
  assign obs1 = {d_mem_req, d_mem_wr, d_adr_src, d_ir_wr, d_pc_wr, d_reg_wr,
                 d_a, d_b, d_alu, d_imm, d_res, d_illegal};
  assign obs2 = {e_mem_req, e_mem_wr, e_adr_src, e_ir_wr, e_pc_wr, e_reg_wr,
                 e_a, e_b, e_alu, e_imm, e_res, e_illegal};

  localparam logic [18:0] MS   = 19'b110_111_00_00_000_000_00_1;
  localparam logic [18:0] MAD  = 19'b001_000_00_00_000_000_00_0;
  localparam logic [18:0] MA   = 19'b000_000_11_00_000_000_00_0;
  localparam logic [18:0] MB   = 19'b000_000_00_11_000_000_00_0;
  localparam logic [18:0] MALU = 19'b000_000_00_00_111_000_00_0;
  localparam logic [18:0] MIMM = 19'b000_000_00_00_000_111_00_0;
  localparam logic [18:0] MRES = 19'b000_000_00_00_000_000_11_0;
  localparam logic [18:0] MALL = 19'h7ffff;
  localparam logic [18:0] MF   = MS | MAD | MA | MB | MALU | MRES;
  localparam logic [18:0] MD   = MS | MA | MB | MALU;

  typedef struct {
    string       tag;
    logic [18:0] exp;
    logic [18:0] msk;
  } ent_t;

  ent_t sb[$];

  function automatic logic [18:0] ov(
    input logic mq, input logic mw, input logic ad,
    input logic iw, input logic pw, input logic rw,
    input logic [1:0] a, input logic [1:0] b,
    input logic [2:0] alu, input logic [2:0] imm,
    input logic [1:0] res, input logic il);
    return {mq, mw, ad, iw, pw, rw, a, b, alu, imm, res, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] x);
    n_chk++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, o, x);
    end
  endtask

  // push expectation for this cycle, compare on the falling edge
  task automatic step(input string tag, input logic [18:0] exp,
                      input logic [18:0] msk);
    ent_t e;
    sb.push_back('{tag, exp, msk});
    @(negedge clk);
    s2 = obs2;
    e = sb.pop_front();
    chk(e.tag, 32'(obs1 & e.msk), 32'(e.exp & e.msk));
    @(posedge clk);
    #1;
  endtask

  task automatic setins(input logic [6:0] o, input logic [2:0] f,
                        input logic [6:0] g);
    op = o;
    f3 = f;
    f7 = g;
  endtask

  task automatic fetch(input string t);
    mem_ready = 1'b1;
    step({t, "_fetch"},
      ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10,
         3'b000, 3'b000, 2'b10, 1'b0), MF);
  endtask

  task automatic decode(input string t, input logic [2:0] imm,
                        input logic ci);
    mem_ready = 1'b0;
    step({t, "_dec"},
      ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01,
         3'b000, imm, 2'b00, 1'b0), ci ? (MD | MIMM) : MD);
    mem_ready = 1'b1;
  endtask

  task automatic alu_wb(input string t);
    step({t, "_wb"},
      ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
         3'b000, 3'b000, 2'b00, 1'b0), MS | MRES);
  endtask

  localparam logic [18:0] V_TRAP = 19'b000_000_00_00_000_000_00_1;

  initial begin
    @(posedge clk);
    #1;
    step("rst_outs", 19'd0, MALL);
    chk("rst_instret", 32'(d_instret), 32'd0);
    chk("rst_instret2", e_instret, 32'd0);
    rst = 1'b0;

    setins(7'b0110011, 3'b000, 7'b0100000);
    fetch("rsub");
    decode("rsub", 3'b000, 1'b0);
    step("rsub_ex", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00,
         3'b001, 3'b000, 2'b00, 1'b0), MD);
    alu_wb("rsub");
    chk("instret_rsub", 32'(d_instret), 32'd1);

    setins(7'b0010011, 3'b000, 7'b0100000);
    fetch("iadd");
    decode("iadd", 3'b000, 1'b1);
    step("iadd_ex", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
         3'b000, 3'b000, 2'b00, 1'b0), MD | MIMM);
    alu_wb("iadd");

    setins(7'b0110011, 3'b110, 7'b0000000);
    fetch("ror");
    decode("ror", 3'b000, 1'b0);
    step("ror_ex", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00,
         3'b011, 3'b000, 2'b00, 1'b0), MD);
    alu_wb("ror");
    chk("instret_ror", 32'(d_instret), 32'd3);

    setins(7'b0000011, 3'b010, 7'b0000000);
    fetch("lw");
    decode("lw", 3'b000, 1'b1);
    step("lw_adr", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
         3'b000, 3'b000, 2'b00, 1'b0), MD | MIMM);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("lw_wait", ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
           3'b000, 3'b000, 2'b00, 1'b0), MS | MAD);
    mem_ready = 1'b1;
    step("lw_rd", ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
         3'b000, 3'b000, 2'b00, 1'b0), MS | MAD);
    step("lw_wb", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
         3'b000, 3'b000, 2'b01, 1'b0), MS | MRES);
    chk("instret_lw", 32'(d_instret), 32'd4);

    setins(7'b0100011, 3'b010, 7'b0000000);
    fetch("sw");
    decode("sw", 3'b001, 1'b1);
    step("sw_adr", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
         3'b000, 3'b001, 2'b00, 1'b0), MD | MIMM);
    step("sw_wr", ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
         3'b000, 3'b000, 2'b00, 1'b0), MS | MAD);

    setins(7'b1100011, 3'b000, 7'b0000000);
    zero = 1'b1;
    fetch("beq_t");
    decode("beq_t", 3'b010, 1'b1);
    step("beq_taken", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00,
         3'b001, 3'b000, 2'b00, 1'b0), MD | MRES);
    zero = 1'b0;
    fetch("beq_n");
    decode("beq_n", 3'b010, 1'b1);
    step("beq_not", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00,
         3'b001, 3'b000, 2'b00, 1'b0), MD | MRES);
    setins(7'b1100011, 3'b001, 7'b0000000);
    fetch("bne");
    decode("bne", 3'b010, 1'b1);
    step("bne_taken", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00,
         3'b001, 3'b000, 2'b00, 1'b0), MD | MRES);
    chk("instret_br", 32'(d_instret), 32'd8);

    setins(7'b1101111, 3'b000, 7'b0000000);
    fetch("jal");
    decode("jal", 3'b011, 1'b1);
    step("jal", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10,
         3'b000, 3'b000, 2'b00, 1'b0), MD | MRES);
    alu_wb("jal");

    setins(7'b1100111, 3'b000, 7'b0000000);
    fetch("jalr");
    decode("jalr", 3'b000, 1'b1);
    step("jalr", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
         3'b000, 3'b000, 2'b00, 1'b0), MD | MIMM);
    step("jalr_pc", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10,
         3'b000, 3'b000, 2'b00, 1'b0), MD | MRES);
    alu_wb("jalr");
    chk("instret_jalr", 32'(d_instret), 32'd10);
    chk("instret_jalr2", e_instret, 32'd10);

    setins(7'b0100011, 3'b010, 7'b0000000);
    fetch("swr");
    decode("swr", 3'b001, 1'b1);
    step("swr_adr", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
         3'b000, 3'b001, 2'b00, 1'b0), MD | MIMM);
    mem_ready = 1'b0;
    step("swr_wait", ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
         3'b000, 3'b000, 2'b00, 1'b0), MS | MAD);
    rst = 1'b1;
    #1;
    chk("rst_mid_memwr", 32'(d_mem_wr), 32'd0);
    chk("rst_mid_memreq", 32'(d_mem_req), 32'd0);
    chk("rst_mid_instret", 32'(d_instret), 32'd0);
    chk("rst_mid_instret2", e_instret, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    setins(7'b0110111, 3'b000, 7'b0000000);
    for (int i = 0; i < 17; i++) begin
      fetch("lui");
      decode("lui", 3'b100, 1'b1);
      step("lui", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
           3'b000, 3'b100, 2'b11, 1'b0), MS | MIMM | MRES);
    end
    chk("instret_wrap", 32'(d_instret), 32'd1);
    chk("instret_17", e_instret, 32'd17);

    setins(7'b1100011, 3'b100, 7'b0000000);
    sign = 1'b1;
    fetch("blt");
    decode("blt", 3'b010, 1'b1);
    step("blt_trap", V_TRAP, MS);
    chk("blt_ext_pcwr", 32'(s2[14]), 32'd1);
    chk("blt_ext_noill", 32'(s2[0]), 32'd0);
    setins(7'b0110111, 3'b000, 7'b0000000);
    step("trap_hold1", V_TRAP, MS);
    step("trap_hold2", V_TRAP, MS);
    chk("trap_instret", 32'(d_instret), 32'd1);

    rst = 1'b1;
    step("rst_trap", 19'd0, MALL);
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      step("wd_wait", ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
           3'b000, 3'b000, 2'b10, 1'b0), MF);
    step("wd_trap", V_TRAP, MS);
    chk("wd_off_req", 32'(s2[18]), 32'd1);
    mem_ready = 1'b1;
    step("wd_hold", V_TRAP, MS);
    chk("wd_instret", 32'(d_instret), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
